// File: rtl/log_arbiter.sv
// Logging arbiter: per-channel decimation and single-entry holding, then a
// round-robin arbiter that emits one log word per cycle.

// One logging channel: enable, decimator, holding register, overflow flag.
module log_chan_slot #(
    parameter int W_LDATA = 18,
    parameter int W_DEC   = 10
) (
    input  logic               pid_clk_in,
    input  logic               sys_rst_in,
    input  logic               sample_dv,
    input  logic [W_LDATA-1:0] sample_data,
    input  logic               en_wr,
    input  logic               en_wdata,
    input  logic               dec_wr,
    input  logic [W_DEC-1:0]   dec_wdata,
    input  logic               ovf_clr,
    input  logic               grant,
    output logic               pending,
    output logic [W_LDATA-1:0] hold_data,
    output logic               ovf
);
    logic             en;
    logic             fresh;   // first sample after reset/dec write always passes
    logic [W_DEC-1:0] dec_val;
    logic [W_DEC-1:0] dec_cnt;
    logic             capture;

    // Decision uses pre-write state so a coinciding config write never affects it
    assign capture = sample_dv && en && (fresh || (dec_cnt >= dec_val));

    // Channel state: config, decimation count, holding register, sticky overflow
    always_ff @(posedge pid_clk_in) begin
        if (sys_rst_in) begin
            en        <= 1'b1;
            fresh     <= 1'b1;
            dec_val   <= '0;
            dec_cnt   <= '0;
            pending   <= 1'b0;
            hold_data <= '0;
            ovf       <= 1'b0;
        end else begin
            if (en_wr)
                en <= en_wdata;

            if (dec_wr) begin
                dec_val <= dec_wdata;
                dec_cnt <= '0;
                fresh   <= 1'b1;
            end else if (sample_dv && en) begin
                if (capture) begin
                    dec_cnt <= '0;
                    fresh   <= 1'b0;
                end else begin
                    dec_cnt <= dec_cnt + 1'b1;
                end
            end

            // A capture on the grant cycle refills the slot; old data is what leaves
            if (capture) begin
                hold_data <= sample_data;
                pending   <= 1'b1;
            end else if (grant) begin
                pending   <= 1'b0;
            end

            // Newly lost sample beats a simultaneous clear
            if (capture && pending && !grant)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
        end
    end
endmodule

module log_arbiter #(
    parameter int          N_CHAN           = 8,
    parameter int          W_LCHAN          = 5,
    parameter int          W_LDATA          = 18,
    parameter int          W_WR_ADDR        = 16,
    parameter int          W_WR_CHAN        = 5,
    parameter int          W_WR_DATA        = 49,
    parameter int          W_DEC            = 10,
    parameter logic [15:0] LOG_DEC_RQST     = 16'h0020,
    parameter logic [15:0] LOG_EN_RQST      = 16'h0021,
    parameter logic [15:0] LOG_OVF_CLR_RQST = 16'h0022
) (
    input  logic                        pid_clk_in,
    input  logic                        sys_rst_in,
    input  logic [N_CHAN-1:0]           chan_dv_in,
    input  logic [N_CHAN*W_LDATA-1:0]   chan_data_in,
    input  logic                        wr_en_in,
    input  logic [W_WR_ADDR-1:0]        wr_addr_in,
    input  logic [W_WR_CHAN-1:0]        wr_chan_in,
    input  logic [W_WR_DATA-1:0]        wr_data_in,
    output logic                        log_dv_out,
    output logic [W_LCHAN-1:0]          log_chan_out,
    output logic [W_LDATA-1:0]          log_data_out,
    output logic [N_CHAN-1:0]           log_ovf_out
);
    logic                             dec_sel;
    logic                             en_wr;
    logic                             ovf_clr;
    logic [N_CHAN-1:0]                pending;
    logic [N_CHAN-1:0][W_LDATA-1:0]   hold;
    logic [N_CHAN-1:0]                grant;
    logic                             gnt_vld;
    logic [W_LCHAN-1:0]               gnt_idx;
    logic [W_LDATA-1:0]               gnt_data;
    logic [W_LCHAN-1:0]               last_grant;
    logic                             unused_wr_data;

    assign dec_sel        = wr_en_in && (wr_addr_in == W_WR_ADDR'(LOG_DEC_RQST));
    assign en_wr          = wr_en_in && (wr_addr_in == W_WR_ADDR'(LOG_EN_RQST));
    assign ovf_clr        = wr_en_in && (wr_addr_in == W_WR_ADDR'(LOG_OVF_CLR_RQST));
    assign unused_wr_data = ^wr_data_in;

    for (genvar k = 0; k < N_CHAN; k++) begin : g_slot
        log_chan_slot #(
            .W_LDATA (W_LDATA),
            .W_DEC   (W_DEC)
        ) u_slot (
            .pid_clk_in  (pid_clk_in),
            .sys_rst_in  (sys_rst_in),
            .sample_dv   (chan_dv_in[k]),
            .sample_data (chan_data_in[k*W_LDATA +: W_LDATA]),
            .en_wr       (en_wr),
            .en_wdata    (wr_data_in[k]),
            .dec_wr      (dec_sel && (wr_chan_in == W_WR_CHAN'(k))),
            .dec_wdata   (wr_data_in[W_DEC-1:0]),
            .ovf_clr     (ovf_clr),
            .grant       (grant[k]),
            .pending     (pending[k]),
            .hold_data   (hold[k]),
            .ovf         (log_ovf_out[k])
        );
    end

    // Round-robin pick: lowest pending above last_grant, else lowest at/below it
    always_comb begin
        logic               hi_vld;
        logic [W_LCHAN-1:0] hi_idx;
        logic               lo_vld;
        logic [W_LCHAN-1:0] lo_idx;
        hi_vld = 1'b0;
        hi_idx = '0;
        lo_vld = 1'b0;
        lo_idx = '0;
        for (int k = N_CHAN - 1; k >= 0; k--) begin
            if (pending[k]) begin
                if (k > int'(last_grant)) begin
                    hi_vld = 1'b1;
                    hi_idx = W_LCHAN'(k);
                end else begin
                    lo_vld = 1'b1;
                    lo_idx = W_LCHAN'(k);
                end
            end
        end
        gnt_vld = hi_vld || lo_vld;
        gnt_idx = hi_vld ? hi_idx : lo_idx;
    end

    // One-hot grant and the data of the granted slot
    always_comb begin
        grant    = '0;
        gnt_data = '0;
        for (int k = 0; k < N_CHAN; k++) begin
            if (gnt_vld && (gnt_idx == W_LCHAN'(k))) begin
                grant[k] = 1'b1;
                gnt_data = hold[k];
            end
        end
    end

    // Registered log output; channel/data hold their value on idle cycles
    always_ff @(posedge pid_clk_in) begin
        if (sys_rst_in) begin
            log_dv_out   <= 1'b0;
            log_chan_out <= '0;
            log_data_out <= '0;
            last_grant   <= W_LCHAN'(N_CHAN - 1);
        end else begin
            log_dv_out <= gnt_vld;
            if (gnt_vld) begin
                log_chan_out <= gnt_idx;
                log_data_out <= gnt_data;
                last_grant   <= gnt_idx;
            end
        end
    end
endmodule
